// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes and FSM state encoding shared by the multiply/divide unit
package muldiv_pkg;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;
endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: one-bit-per-step shift-add multiply / restoring divide datapath on unsigned magnitudes
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic                 div,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic [2*WIDTH-1:0]   acc
);
  logic [WIDTH-1:0] m;
  logic [WIDTH:0]   sum, rsh, diff;
  assign sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
  assign rsh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff = rsh - {1'b0, m};
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      m   <= '0;
    end else if (load) begin
      acc <= {{WIDTH{1'b0}}, a_in};
      m   <= b_in;
    end else if (step) begin
      acc <= div ? {(diff[WIDTH] ? rsh[WIDTH-1:0] : diff[WIDTH-1:0]), acc[WIDTH-2:0], !diff[WIDTH]}
                 : {sum, acc[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with MTHI/MTLO and architectural HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_e             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic               neg_q, sa_q, div_q, dz_q;
  logic               go, load, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
  logic [2*WIDTH-1:0] acc, prod;
  assign go    = state == S_IDLE && start && !cancel;
  assign load  = go && !op[2];
  assign a_neg = !op[0] && a[WIDTH-1];
  assign b_neg = !op[0] && b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign prod  = neg_q ? -acc : acc;
  assign quo   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem   = sa_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign busy  = state != S_IDLE;
  assign done  = state == S_FIX;
  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (state == S_RUN),
    .div  (div_q),
    .a_in (a_mag),
    .b_in (b_mag),
    .acc  (acc)
  );
  always_comb begin
    state_n = cancel                                      ? S_IDLE :
              load                                        ? S_RUN  :
              (state == S_RUN && cnt == CNT_W'(WIDTH - 1)) ? S_FIX  :
              state == S_FIX                              ? S_IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      neg_q <= 1'b0;
      sa_q  <= 1'b0;
      div_q <= 1'b0;
      dz_q  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= load ? '0 : state == S_RUN ? cnt + CNT_W'(1) : cnt;
      if (load) begin
        neg_q <= a_neg ^ b_neg;
        sa_q  <= a_neg;
        div_q <= op[1];
        dz_q  <= b == '0;
      end
      if (go && op == OP_MTHI) hi <= a;
      if (go && op == OP_MTLO) lo <= a;
      if (state == S_FIX && !cancel) begin
        hi <= div_q ? rem : prod[2*WIDTH-1:WIDTH];
        lo <= div_q ? (dz_q ? '1 : quo) : prod[WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8
module tb_muldiv_unit;
  import muldiv_pkg::*;
  logic        clk = 1'b0;
  logic        rst, start, cancel, start8, cancel8;
  logic [2:0]  op, op8;
  logic [31:0] a, b, hi, lo;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy, done, busy8, done8;
  int          tests = 0, fails = 0, nb, nd;
  always #5 clk = ~clk;
  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .cancel(cancel8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(output int nbusy, output int ndone);
    nbusy = 0;
    ndone = 0;
    for (int i = 1; i <= 100; i++) begin
      if (!busy) break;
      nbusy++;
      if (done) ndone = i;
      @(negedge clk);
    end
  endtask
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] ehi, input logic [31:0] elo);
    issue(o, x, y);
    wait_done(nb, nd);
    chk({tag, "_busy_cycles"}, nb, 33);
    chk({tag, "_done_cycle"}, nd, 33);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; cancel8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;
    run("mult_neg3x7", OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run("div_neg7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    run("div_neg_by0", OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    run("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    issue(OP_MULT, 32'd6, 32'd7);
    repeat (9) @(negedge clk);
    chk("cancel_busy_before", busy, 1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy_after", busy, 0);
    chk("cancel_done", done, 0);
    chk("cancel_hi_kept", hi, 32'h00000000);
    chk("cancel_lo_kept", lo, 32'h80000000);
    start = 1'b1; op = OP_MULT; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(nb, nd);
    chk("restart_busy_cycles", nb, 33);
    chk("restart_hi", hi, 32'd0);
    chk("restart_lo", lo, 32'd42);
    issue(OP_MTHI, 32'hA5A5A5A5, 32'd0);
    chk("mthi_hi", hi, 32'hA5A5A5A5);
    chk("mthi_lo", lo, 32'd42);
    chk("mthi_busy", busy, 0);
    chk("mthi_done", done, 0);
    cancel = 1'b1;
    issue(OP_MTHI, 32'h12345678, 32'd0);
    cancel = 1'b0;
    chk("mthi_cancel_hi", hi, 32'hA5A5A5A5);
    chk("mthi_cancel_busy", busy, 0);
    issue(3'b110, 32'h11111111, 32'h22222222);
    chk("nop_busy", busy, 0);
    chk("nop_hi", hi, 32'hA5A5A5A5);
    chk("nop_lo", lo, 32'd42);
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    start = 1'b1; op = OP_MTLO; a = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    wait_done(nb, nd);
    chk("mtlo_busy_done_seen", nd > 0, 1);
    chk("mtlo_busy_lo", lo, 32'd14);
    chk("mtlo_busy_hi", hi, 32'd2);
    issue(OP_DIVU, 32'd100, 32'd3);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    start8 = 1'b1; op8 = OP_MULTU; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0;
    nb = 0;
    nd = 0;
    for (int i = 1; i <= 100; i++) begin
      if (!busy8) break;
      nb++;
      if (done8) nd = i;
      @(negedge clk);
    end
    chk("w8_busy_cycles", nb, 9);
    chk("w8_done_cycle", nd, 9);
    chk("w8_hi", hi8, 8'hFE);
    chk("w8_lo", lo8, 8'h01);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
